// File: rtl/oq_regs_pkg.sv
// -----------------------------------------------------------------------------
// oq_regs_pkg
// Shared definitions for the output-queue register block.
//   - log2            : ceiling log2, usable in constant expressions
//   - SRAM_ADDR_WIDTH : output-queue SRAM address width
//   - CTRL_WIDTH      : bytes per data word
//   - NUM_OUTPUT_QUEUES, NUM_OQ_WIDTH : queue count and index width
//   - MIN_PKT, PKTS_IN_RAM_WIDTH      : smallest packet in words, per-queue count width
//   - stage_t         : one pipeline stage record (valid, queue, count)
//   - stage_dir_e     : which event kind a pipeline path handles
// -----------------------------------------------------------------------------
package oq_regs_pkg;

   // Smallest r such that 2**r >= value; a value of 1 yields 0.
   function automatic int log2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   localparam int SRAM_ADDR_WIDTH   = 13;
   localparam int CTRL_WIDTH        = 8;
   localparam int NUM_OUTPUT_QUEUES = 8;
   localparam int NUM_OQ_WIDTH      = log2(NUM_OUTPUT_QUEUES);
   localparam int MIN_PKT           = 60 / CTRL_WIDTH + 1;
   localparam int PKTS_IN_RAM_WIDTH = log2((2 ** SRAM_ADDR_WIDTH) / MIN_PKT);

   typedef logic [NUM_OQ_WIDTH-1:0]      oq_t;
   typedef logic [PKTS_IN_RAM_WIDTH-1:0] pkt_count_t;

   localparam pkt_count_t PKT_COUNT_MAX = '1;

   typedef struct packed {
      logic       valid;
      oq_t        oq;
      pkt_count_t count;
   } stage_t;

   typedef enum logic {
      DIR_STORE,
      DIR_REMOVE
   } stage_dir_e;

endpackage

// File: rtl/oq_regs_pkt_count_update_if.sv
// -----------------------------------------------------------------------------
// oq_regs_pkt_count_update_if
// Count-update bus from the packet-count tracker to the empty-flag evaluator.
//   dst_update / dst_oq                          : store event entered read stage
//   dst_num_pkts_in_q / dst_num_pkts_in_q_done   : count after the store
//   src_update / src_oq                          : remove event entered read stage
//   src_num_pkts_in_q / src_num_pkts_in_q_done   : count after the remove
//   count_overflow / count_underflow             : error pulses aligned with done
// master = tracker (producer), slave = empty evaluator (consumer).
// -----------------------------------------------------------------------------
interface oq_regs_pkt_count_update_if;
   import oq_regs_pkg::*;

   logic       dst_update;
   oq_t        dst_oq;
   pkt_count_t dst_num_pkts_in_q;
   logic       dst_num_pkts_in_q_done;
   logic       src_update;
   oq_t        src_oq;
   pkt_count_t src_num_pkts_in_q;
   logic       src_num_pkts_in_q_done;
   logic       count_overflow;
   logic       count_underflow;

   modport master (
      output dst_update, dst_oq, dst_num_pkts_in_q, dst_num_pkts_in_q_done,
      output src_update, src_oq, src_num_pkts_in_q, src_num_pkts_in_q_done,
      output count_overflow, count_underflow
   );

   modport slave (
      input dst_update, dst_oq, dst_num_pkts_in_q, dst_num_pkts_in_q_done,
      input src_update, src_oq, src_num_pkts_in_q, src_num_pkts_in_q_done,
      input count_overflow, count_underflow
   );

endinterface

// File: rtl/oq_pkt_count_stage.sv
// -----------------------------------------------------------------------------
// oq_pkt_count_stage
// One read/write pipeline path for a single event kind (store or remove).
//   clk, reset      : clock, synchronous active-high reset
//   event_valid/oq  : incoming one-cycle event strobe and its queue
//   rd_count        : count of r_oq as it will be after this cycle's writes
//   base_count      : value the write-stage arithmetic is applied to
//   r_oq            : queue currently in the read stage
//   w_stage         : write-stage record (valid, queue, count read in stage R)
//   new_count       : saturating +1 (store) or held-at-zero -1 (remove)
//   update/oq       : read-stage strobe and held queue index
//   num_pkts_in_q/done : write-stage result and its strobe
// -----------------------------------------------------------------------------
module oq_pkt_count_stage
   import oq_regs_pkg::*;
#(
   parameter stage_dir_e DIR = DIR_STORE
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       event_valid,
   input  oq_t        event_oq,
   input  pkt_count_t rd_count,
   input  pkt_count_t base_count,
   output oq_t        r_oq,
   output stage_t     w_stage,
   output pkt_count_t new_count,
   output logic       update,
   output oq_t        oq,
   output pkt_count_t num_pkts_in_q,
   output logic       done
);

   logic       r_valid;
   oq_t        oq_hold;
   pkt_count_t num_hold;

   // Pipeline registers. The read stage captures the event; the write stage
   // captures the count as the top level forwards it, so a back-to-back event
   // on the same queue already sees the previous write. The held queue index
   // and result keep the outputs stable between strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid       <= 1'b0;
         r_oq          <= '0;
         w_stage       <= '0;
         oq_hold       <= '0;
         num_hold      <= '0;
      end else begin
         r_valid       <= event_valid;
         r_oq          <= event_oq;
         w_stage.valid <= r_valid;
         w_stage.oq    <= r_oq;
         w_stage.count <= rd_count;
         if (event_valid) oq_hold <= event_oq;
         if (w_stage.valid) num_hold <= new_count;
      end
   end

   // Write-stage arithmetic. Store saturates at the all-ones count and remove
   // stops at zero; in both cases the count is simply held.
   always_comb begin
      new_count = base_count;
      if (DIR == DIR_STORE) begin
         if (base_count != PKT_COUNT_MAX) new_count = base_count + 1'b1;
      end else begin
         if (base_count != '0) new_count = base_count - 1'b1;
      end
   end

   assign update        = r_valid;
   assign oq            = oq_hold;
   assign done          = w_stage.valid;
   assign num_pkts_in_q = w_stage.valid ? new_count : num_hold;

endmodule

// File: rtl/oq_regs_pkt_count_update.sv
// -----------------------------------------------------------------------------
// oq_regs_pkt_count_update
// Per-output-queue packet-count tracker. Store and remove events each run
// through a two-stage read-modify-write path; results drive the empty-flag
// evaluator through the update bus.
//   clk, reset               : clock, synchronous active-high reset
//   pkt_stored, pkt_stored_oq   : one-cycle store strobe and queue
//   pkt_removed, pkt_removed_oq : one-cycle remove strobe and queue
//   initialize, initialize_oq   : clear one queue's count (write stage)
//   update_bus (master)         : dst/src update, count, done, error pulses
// Optional feature: define OQ_PKT_COUNT_ERR_EN to build overflow/underflow
// detection with sticky flags; otherwise both error outputs are tied low.
// -----------------------------------------------------------------------------
module oq_regs_pkt_count_update
   import oq_regs_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic pkt_stored,
   input  oq_t  pkt_stored_oq,
   input  logic pkt_removed,
   input  oq_t  pkt_removed_oq,
   input  logic initialize,
   input  oq_t  initialize_oq,
   oq_regs_pkt_count_update_if.master update_bus
);

   pkt_count_t count      [NUM_OUTPUT_QUEUES];
   pkt_count_t count_next [NUM_OUTPUT_QUEUES];

   oq_t        dst_r_oq,   src_r_oq;
   stage_t     dst_w,      src_w;
   pkt_count_t dst_new,    src_new;
   pkt_count_t dst_base,   src_base;
   pkt_count_t dst_rd,     src_rd;
   logic       dst_update, src_update;
   oq_t        dst_oq,     src_oq;
   pkt_count_t dst_num,    src_num;
   logic       dst_done,   src_done;
   logic       same_q;

   // When both paths finish on the same queue the remove is applied on top of
   // the store result, so the remove path takes the store's new value as base.
   assign same_q   = dst_w.valid && src_w.valid && (dst_w.oq == src_w.oq);
   assign dst_base = dst_w.count;
   assign src_base = same_q ? dst_new : src_w.count;

   // Next value of every count: store, then remove, then initialize, in that
   // order. The read stages index this array, which forwards all
   // same-cycle writes to a following event on the same queue.
   always_comb begin
      count_next = count;
      if (dst_w.valid) count_next[dst_w.oq] = dst_new;
      if (src_w.valid) count_next[src_w.oq] = src_new;
      if (initialize)  count_next[initialize_oq] = '0;
   end

   assign dst_rd = count_next[dst_r_oq];
   assign src_rd = count_next[src_r_oq];

   // Count storage; every queue returns to zero on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) count[i] <= '0;
      end else begin
         count <= count_next;
      end
   end

   oq_pkt_count_stage #(.DIR(DIR_STORE)) u_dst_stage (
      .clk           (clk),
      .reset         (reset),
      .event_valid   (pkt_stored),
      .event_oq      (pkt_stored_oq),
      .rd_count      (dst_rd),
      .base_count    (dst_base),
      .r_oq          (dst_r_oq),
      .w_stage       (dst_w),
      .new_count     (dst_new),
      .update        (dst_update),
      .oq            (dst_oq),
      .num_pkts_in_q (dst_num),
      .done          (dst_done)
   );

   oq_pkt_count_stage #(.DIR(DIR_REMOVE)) u_src_stage (
      .clk           (clk),
      .reset         (reset),
      .event_valid   (pkt_removed),
      .event_oq      (pkt_removed_oq),
      .rd_count      (src_rd),
      .base_count    (src_base),
      .r_oq          (src_r_oq),
      .w_stage       (src_w),
      .new_count     (src_new),
      .update        (src_update),
      .oq            (src_oq),
      .num_pkts_in_q (src_num),
      .done          (src_done)
   );

   assign update_bus.dst_update             = dst_update;
   assign update_bus.dst_oq                 = dst_oq;
   assign update_bus.dst_num_pkts_in_q      = dst_num;
   assign update_bus.dst_num_pkts_in_q_done = dst_done;
   assign update_bus.src_update             = src_update;
   assign update_bus.src_oq                 = src_oq;
   assign update_bus.src_num_pkts_in_q      = src_num;
   assign update_bus.src_num_pkts_in_q_done = src_done;

`ifdef OQ_PKT_COUNT_ERR_EN
   logic overflow_now, underflow_now;
   logic overflow_seen, underflow_seen;

   // Errors are judged on the base each path actually applies to, so a
   // colliding remove sees the count after the store.
   assign overflow_now  = dst_w.valid && (dst_base == PKT_COUNT_MAX);
   assign underflow_now = src_w.valid && (src_base == '0);

   // Sticky copies of the error pulses, kept until the next reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_seen  <= 1'b0;
         underflow_seen <= 1'b0;
      end else begin
         overflow_seen  <= overflow_seen  | overflow_now;
         underflow_seen <= underflow_seen | underflow_now;
      end
   end

   assign update_bus.count_overflow  = overflow_now;
   assign update_bus.count_underflow = underflow_now;
`else
   assign update_bus.count_overflow  = 1'b0;
   assign update_bus.count_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_oq_regs_pkt_count_update.sv
// -----------------------------------------------------------------------------
// tb_oq_regs_pkt_count_update
// Directed bench for the packet-count tracker. A cycle-level model of the
// queue counts is compared against the update bus every cycle, and the
// directed scenarios pin results to hand-computed values.
// -----------------------------------------------------------------------------
module tb_oq_regs_pkt_count_update;
   import oq_regs_pkg::*;

   localparam int MAX_COUNT = 1023;
`ifdef OQ_PKT_COUNT_ERR_EN
   localparam int ERR_EN = 1;
`else
   localparam int ERR_EN = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic pkt_stored = 1'b0;
   oq_t  pkt_stored_oq = '0;
   logic pkt_removed = 1'b0;
   oq_t  pkt_removed_oq = '0;
   logic initialize = 1'b0;
   oq_t  initialize_oq = '0;

   oq_regs_pkt_count_update_if bus ();

   oq_regs_pkt_count_update dut (
      .clk            (clk),
      .reset          (reset),
      .pkt_stored     (pkt_stored),
      .pkt_stored_oq  (pkt_stored_oq),
      .pkt_removed    (pkt_removed),
      .pkt_removed_oq (pkt_removed_oq),
      .initialize     (initialize),
      .initialize_oq  (initialize_oq),
      .update_bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   typedef struct {
      int cyc;
      int oq;
      int num;
      int err;
   } log_t;

   log_t dst_log[$];
   log_t src_log[$];

   // Compare one value and report it on mismatch.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Field of a logged done event; -1 when the entry does not exist.
   // field: 0 cycle, 1 queue, 2 count, 3 error flag
   function automatic int logField(input bit src, input int idx, input int field);
      log_t e;
      if (src ? (idx >= src_log.size()) : (idx >= dst_log.size())) return -1;
      e = src ? src_log[idx] : dst_log[idx];
      case (field)
         0:       return e.cyc;
         1:       return e.oq;
         2:       return e.num;
         default: return e.err;
      endcase
   endfunction

   // Model state: counts per queue and strobe history ([1] = previous cycle,
   // [2] = two cycles ago).
   int model_cnt [8];
   bit st_v [3];
   int st_oq [3];
   bit rm_v [3];
   int rm_oq [3];
   int last_dst_num = 0;
   int last_src_num = 0;
   bit live = 1'b0;

   // Every mid-cycle: apply the events finishing this cycle to the model in
   // store-then-remove order, compare the bus, log done events, then apply
   // any initialize and advance the history.
   always @(negedge clk) begin
      int old, e_dn, e_sn;
      bit ovf, unf;
      cycle++;
      st_v[0]  = pkt_stored;
      st_oq[0] = int'(pkt_stored_oq);
      rm_v[0]  = pkt_removed;
      rm_oq[0] = int'(pkt_removed_oq);
      if (live) begin
         ovf  = 1'b0;
         unf  = 1'b0;
         e_dn = last_dst_num;
         e_sn = last_src_num;
         if (st_v[2]) begin
            old  = model_cnt[st_oq[2]];
            ovf  = (old == MAX_COUNT);
            e_dn = ovf ? old : old + 1;
            model_cnt[st_oq[2]] = e_dn;
         end
         if (rm_v[2]) begin
            old  = model_cnt[rm_oq[2]];
            unf  = (old == 0);
            e_sn = unf ? 0 : old - 1;
            model_cnt[rm_oq[2]] = e_sn;
         end
         checkOutput("dst_update", int'(bus.dst_update), int'(st_v[1]));
         checkOutput("dst_done", int'(bus.dst_num_pkts_in_q_done), int'(st_v[2]));
         checkOutput("dst_num", int'(bus.dst_num_pkts_in_q), e_dn);
         if (st_v[1]) checkOutput("dst_oq", int'(bus.dst_oq), st_oq[1]);
         else if (st_v[2]) checkOutput("dst_oq", int'(bus.dst_oq), st_oq[2]);
         checkOutput("src_update", int'(bus.src_update), int'(rm_v[1]));
         checkOutput("src_done", int'(bus.src_num_pkts_in_q_done), int'(rm_v[2]));
         checkOutput("src_num", int'(bus.src_num_pkts_in_q), e_sn);
         if (rm_v[1]) checkOutput("src_oq", int'(bus.src_oq), rm_oq[1]);
         else if (rm_v[2]) checkOutput("src_oq", int'(bus.src_oq), rm_oq[2]);
         checkOutput("count_overflow", int'(bus.count_overflow), ERR_EN * int'(ovf));
         checkOutput("count_underflow", int'(bus.count_underflow), ERR_EN * int'(unf));
         if (bus.dst_num_pkts_in_q_done)
            dst_log.push_back('{cycle, int'(bus.dst_oq), int'(bus.dst_num_pkts_in_q), int'(bus.count_overflow)});
         if (bus.src_num_pkts_in_q_done)
            src_log.push_back('{cycle, int'(bus.src_oq), int'(bus.src_num_pkts_in_q), int'(bus.count_underflow)});
         if (initialize) model_cnt[int'(initialize_oq)] = 0;
         last_dst_num = e_dn;
         last_src_num = e_sn;
      end
      if (reset) begin
         for (int i = 0; i < 8; i++) model_cnt[i] = 0;
         for (int i = 1; i < 3; i++) begin
            st_v[i] = 1'b0;
            rm_v[i] = 1'b0;
         end
         last_dst_num = 0;
         last_src_num = 0;
         live = 1'b1;
      end else begin
         st_v[2] = st_v[1];  st_oq[2] = st_oq[1];
         st_v[1] = st_v[0];  st_oq[1] = st_oq[0];
         rm_v[2] = rm_v[1];  rm_oq[2] = rm_oq[1];
         rm_v[1] = rm_v[0];  rm_oq[1] = rm_oq[0];
      end
   end

   // Drive one cycle of inputs, then return everything to idle.
   task automatic applyStimulus(input bit st, input int soq, input bit rm, input int roq,
                                input bit in, input int ioq);
      pkt_stored     = st;
      pkt_stored_oq  = oq_t'(soq);
      pkt_removed    = rm;
      pkt_removed_oq = oq_t'(roq);
      initialize     = in;
      initialize_oq  = oq_t'(ioq);
      @(posedge clk);
      #1;
      pkt_stored  = 1'b0;
      pkt_removed = 1'b0;
      initialize  = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic clearLogs();
      dst_log.delete();
      src_log.delete();
   endtask

   // Mixed directed vectors: {store, store_oq, remove, remove_oq, init, init_oq}
   int vectors [12][6] = '{
      '{1, 6, 1, 7, 0, 0},
      '{1, 6, 0, 0, 0, 0},
      '{1, 6, 1, 6, 0, 0},
      '{0, 0, 1, 6, 0, 0},
      '{1, 2, 1, 6, 1, 6},
      '{1, 6, 1, 6, 1, 6},
      '{0, 0, 1, 2, 0, 0},
      '{1, 2, 1, 2, 1, 3},
      '{0, 0, 0, 0, 0, 0},
      '{1, 5, 0, 0, 0, 0},
      '{0, 0, 1, 5, 0, 0},
      '{0, 0, 1, 5, 0, 0}
   };

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset values
      @(negedge clk);
      checkOutput("reset dst_update", int'(bus.dst_update), 0);
      checkOutput("reset dst_done", int'(bus.dst_num_pkts_in_q_done), 0);
      checkOutput("reset dst_oq", int'(bus.dst_oq), 0);
      checkOutput("reset dst_num", int'(bus.dst_num_pkts_in_q), 0);
      checkOutput("reset src_num", int'(bus.src_num_pkts_in_q), 0);
      checkOutput("reset overflow", int'(bus.count_overflow), 0);
      @(posedge clk);
      #1;

      // Three back-to-back stores to oq 2
      clearLogs();
      repeat (3) applyStimulus(1, 2, 0, 0, 0, 0);
      idleCycles(3);
      checkOutput("t1 done count", dst_log.size(), 3);
      checkOutput("t1 num0", logField(0, 0, 2), 1);
      checkOutput("t1 num1", logField(0, 1, 2), 2);
      checkOutput("t1 num2", logField(0, 2, 2), 3);
      checkOutput("t1 oq2", logField(0, 2, 1), 2);
      checkOutput("t1 consecutive", logField(0, 2, 0) - logField(0, 0, 0), 2);

      // Two removes from oq 5 holding one packet
      doReset();
      applyStimulus(1, 5, 0, 0, 0, 0);
      idleCycles(3);
      clearLogs();
      applyStimulus(0, 0, 1, 5, 0, 0);
      applyStimulus(0, 0, 1, 5, 0, 0);
      idleCycles(3);
      checkOutput("t2 done count", src_log.size(), 2);
      checkOutput("t2 num0", logField(1, 0, 2), 0);
      checkOutput("t2 num1", logField(1, 1, 2), 0);
      checkOutput("t2 underflow0", logField(1, 0, 3), 0);
      checkOutput("t2 underflow1", logField(1, 1, 3), ERR_EN);

      // Same-cycle store and remove on oq 1 holding four
      doReset();
      repeat (4) applyStimulus(1, 1, 0, 0, 0, 0);
      idleCycles(3);
      clearLogs();
      applyStimulus(1, 1, 1, 1, 0, 0);
      idleCycles(3);
      checkOutput("t3 dst_num", logField(0, 0, 2), 5);
      checkOutput("t3 src_num", logField(1, 0, 2), 4);
      checkOutput("t3 same cycle", logField(1, 0, 0) - logField(0, 0, 0), 0);
      clearLogs();
      applyStimulus(1, 1, 0, 0, 0, 0);
      idleCycles(3);
      checkOutput("t3 stored 4", logField(0, 0, 2), 5);

      // Saturation on oq 0
      doReset();
      clearLogs();
      repeat (MAX_COUNT) applyStimulus(1, 0, 0, 0, 0, 0);
      idleCycles(3);
      checkOutput("t4 preload count", dst_log.size(), MAX_COUNT);
      checkOutput("t4 preload max", logField(0, MAX_COUNT - 1, 2), 1023);
      checkOutput("t4 preload no ovf", logField(0, MAX_COUNT - 1, 3), 0);
      clearLogs();
      applyStimulus(1, 0, 0, 0, 0, 0);
      idleCycles(3);
      checkOutput("t4 held max", logField(0, 0, 2), 1023);
      checkOutput("t4 overflow", logField(0, 0, 3), ERR_EN);

      // Initialize oq 3 while a store to it is in the write stage
      doReset();
      repeat (7) applyStimulus(1, 3, 0, 0, 0, 0);
      idleCycles(3);
      clearLogs();
      applyStimulus(1, 3, 0, 0, 0, 0);
      idleCycles(1);
      applyStimulus(0, 0, 0, 0, 1, 3);
      idleCycles(3);
      applyStimulus(1, 3, 0, 0, 0, 0);
      idleCycles(3);
      checkOutput("t5 store during init", logField(0, 0, 2), 8);
      checkOutput("t5 after init", logField(0, 1, 2), 1);

      // Reset the cycle after a store strobe
      doReset();
      clearLogs();
      applyStimulus(1, 4, 0, 0, 0, 0);
      doReset();
      idleCycles(3);
      checkOutput("t6 no done", dst_log.size(), 0);
      @(negedge clk);
      checkOutput("t6 dst_update", int'(bus.dst_update), 0);
      checkOutput("t6 dst_num", int'(bus.dst_num_pkts_in_q), 0);
      checkOutput("t6 dst_oq", int'(bus.dst_oq), 0);
      @(posedge clk);
      #1;
      applyStimulus(1, 4, 0, 0, 0, 0);
      idleCycles(3);
      checkOutput("t6 count cleared", logField(0, 0, 2), 1);

      // Mixed collisions and initializes, checked by the model
      doReset();
      for (int i = 0; i < 12; i++)
         applyStimulus(vectors[i][0] != 0, vectors[i][1], vectors[i][2] != 0, vectors[i][3],
                       vectors[i][4] != 0, vectors[i][5]);
      idleCycles(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/oq_regs_pkt_count_update.md
# oq_regs_pkt_count_update

Per-output-queue packet-count tracker inside the output-queue register block. It accepts "packet stored" and "packet removed" events, keeps the count for each queue, and updates it with a pipelined read-modify-write. Its results drive the empty-flag evaluator's dst/src update interface (update strobe + queue index, then count + done strobe). It is the producer end of the interface the empty evaluator consumes.

## Interface
- `SRAM_ADDR_WIDTH`, 13: output-queue SRAM address width.
- `CTRL_WIDTH`, 8: bytes per data word.
- `NUM_OUTPUT_QUEUES`, 8: number of queues.
- `NUM_OQ_WIDTH`, log2(NUM_OUTPUT_QUEUES): queue index width.
- `MIN_PKT`, 60/CTRL_WIDTH+1: minimum packet size in words.
- `PKTS_IN_RAM_WIDTH`, log2((2**SRAM_ADDR_WIDTH)/MIN_PKT): width of a per-queue count.
- `clk`, in, 1: single clock.
- `reset`, in, 1: reset, synchronous and active-high.
- `pkt_stored`, in, 1: one-cycle strobe; one packet was written into queue `pkt_stored_oq`.
- `pkt_stored_oq`, in, NUM_OQ_WIDTH: queue for the store event.
- `pkt_removed`, in, 1: one-cycle strobe; one packet was removed from queue `pkt_removed_oq`.
- `pkt_removed_oq`, in, NUM_OQ_WIDTH: queue for the remove event.
- `initialize`, in, 1: clear the count of `initialize_oq`.
- `initialize_oq`, in, NUM_OQ_WIDTH: queue to clear.
- `dst_update`, out, 1: store event entered the read stage.
- `dst_oq`, out, NUM_OQ_WIDTH: queue of the store event.
- `dst_num_pkts_in_q`, out, PKTS_IN_RAM_WIDTH: count after the store.
- `dst_num_pkts_in_q_done`, out, 1: `dst_num_pkts_in_q` is valid.
- `src_update`, `src_oq`, `src_num_pkts_in_q`, `src_num_pkts_in_q_done`: the same four outputs for remove events.
- `count_overflow`, out, 1: store hit a saturated count.
- `count_underflow`, out, 1: remove hit a zero count.

## Operation
- Storage: internal array `count[NUM_OUTPUT_QUEUES]`, each PKTS_IN_RAM_WIDTH wide. All entries reset to 0.
- Each event path (dst = store, src = remove) is a 2-stage pipeline:
  - Stage R (cycle after the strobe): assert `*_update` with `*_oq`; read the count.
  - Stage W (next cycle): compute the new value, write it back, and present `*_num_pkts_in_q` with `*_done`.
- Arithmetic:
  - Store is +1, saturating at 2^PKTS_IN_RAM_WIDTH−1. At the saturated value the count is held and `count_overflow` pulses for 1 cycle in stage W.
  - Remove is −1, held at 0. At zero the count stays 0 and `count_underflow` pulses.
- Forwarding:
  - Back-to-back events on the same queue must see each other's writes. A stage-R read of a queue being written in stage W takes the stage-W result.
  - No counts may be lost at one event per cycle per path.
- Store and remove reaching stage W on the same queue in the same cycle:
  - Store is applied first, then remove.
  - `dst_num_pkts_in_q` = old+1.
  - `src_num_pkts_in_q` = old+1−1 = old.
  - The stored value is old.
  - Saturation and zero checks are applied sequentially in that order.
- Store and remove on different queues in the same cycle: independent.
- Initialize:
  - Applied in the write stage, after any same-cycle store or remove on the same queue. The final stored value is 0.
  - Done outputs for colliding events still report their computed values.
  - Initialize produces no `*_update` or `*_done` strobes.
- Reset mid-operation: all pipeline valids clear and all counts return to 0 in the cycle `reset` is sampled high; in-flight events are dropped.

## Timing
- Reset values:
  - `dst_update`, `src_update`, `*_done`, `count_overflow`, `count_underflow` = 0.
  - `dst_oq`, `src_oq`, `*_num_pkts_in_q` = 0.
- Strobe at cycle N: `*_update` at N+1, `*_done` at N+2. Throughput: one event per path per cycle.
- `*_oq` holds its value from the `*_update` cycle through the `*_done` cycle.
- `*_num_pkts_in_q` is valid only while `*_done` is high; it holds its value otherwise.
- Error pulses are aligned with the `*_done` of the offending event.

## Configuration
- `OQ_PKT_COUNT_ERR_EN` defined:
  - Saturation/underflow detection drives `count_overflow` and `count_underflow`.
  - Internal sticky flags are kept (cleared by reset).
- Undefined:
  - Both error outputs are tied to 0 and no detection logic is built.
  - Counts still saturate and hold at 0.

## Structure
- Shared package (`oq_regs_pkg`):
  - the log2 function;
  - derived-width constants (NUM_OQ_WIDTH, PKTS_IN_RAM_WIDTH);
  - pipeline-stage record typedef (valid, oq, count).
- Sub-module `oq_pkt_count_stage`: one R/W pipeline path with forwarding. It is instantiated twice, once for store and once for remove. The top level resolves same-queue collisions and initialize.

## Test plan
- Three stores to oq 2 on consecutive cycles from reset → `dst_done` on 3 consecutive cycles with counts 1, 2, 3; `dst_oq`=2.
- Count of oq 5 is 1; remove at N, remove at N+1 → `src_num_pkts_in_q` = 0 then 0; second remove raises `count_underflow` (macro on) or 0 (macro off).
- Count of oq 1 is 4; store and remove to oq 1 in the same cycle → `dst_num_pkts_in_q`=5, `src_num_pkts_in_q`=4, stored count 4, both done in the same cycle.
- Preload oq 0 to max (2^PKTS_IN_RAM_WIDTH−1); store → count stays max, `count_overflow` pulses 1 cycle.
- Count of oq 3 is 7; initialize oq 3 in the same cycle a store to oq 3 is in stage W → `dst_num_pkts_in_q`=8; the next store reports 1.
- Reset asserted the cycle after a store strobe → no `dst_done`; all outputs 0; counts 0.
